fft_frame_controller: RTL

//  Frame sequencer in front of fft_processor. Gates a streaming I/Q source into

---
 rtl/fft_ctrl_pkg.sv | 19 +
 rtl/fft_ctrl_watchdog.sv | 33 +++
 rtl/fft_frame_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame controller.
//   fft_ctrl_state_e : controller FSM states, also exported on the debug port
//   FFT_IDX_W        : width of the fft_processor output bin index
//   RESYNC_CYCLES    : cycles fft_rst_n is held low after abort, timeout or reset
package fft_ctrl_pkg;

  localparam int FFT_IDX_W     = 12;
  localparam int RESYNC_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_WAIT_OUT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_SKIP     = 3'd4,
    ST_RESYNC   = 3'd5
  } fft_ctrl_state_e;

endpackage

// File: rtl/fft_ctrl_watchdog.sv
// Per-frame watchdog for the FFT computation/drain phase.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : synchronous clear of the count (dominates en)
//   en         : count while high
//   expired    : combinational terminal-count pulse, high while en=1 and the
//                count sits at TIMEOUT_CYCLES-1
module fft_ctrl_watchdog #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The count parks at LAST so the pulse stays asserted until the owner reacts.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/fft_frame_controller.sv
// Frame sequencer in front of fft_processor.
// Cuts a streaming I/Q source into exact FFT_SIZE-sample frames, blocks input
// while the FFT computes and drains, optionally discards skip_frames whole
// frames between transforms, and resynchronises the FFT through fft_rst_n on
// abort or watchdog timeout.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   enable                      run request, sampled in IDLE and at frame end
//   abort                       1-cycle abort pulse (ignored in IDLE)
//   skip_frames                 frames discarded between transforms
//   s_valid/s_ready/s_real/s_imag  input sample stream
//   fft_real_in/fft_imag_in/fft_data_valid/fft_rst_n  to fft_processor
//   fft_valid/fft_index         from fft_processor
//   busy, frame_done, frame_count, err_timeout  status
//   state_dbg                   current FSM state
// Handshake: a sample transfers on every rising edge where s_valid && s_ready;
// s_ready depends only on state (never on s_valid), and the source must hold
// s_valid and data stable until the transfer happens.
module fft_frame_controller
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_SIZE        = 4096,
  parameter int DATA_WIDTH      = 24,
  parameter int SKIP_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int FRAME_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       abort,
  input  logic [SKIP_WIDTH-1:0]      skip_frames,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_real,
  input  logic [DATA_WIDTH-1:0]      s_imag,
  output logic [DATA_WIDTH-1:0]      fft_real_in,
  output logic [DATA_WIDTH-1:0]      fft_imag_in,
  output logic                       fft_data_valid,
  output logic                       fft_rst_n,
  input  logic                       fft_valid,
  input  logic [FFT_IDX_W-1:0]       fft_index,
  output logic                       busy,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       err_timeout,
  output fft_ctrl_state_e            state_dbg
);

  localparam int CNT_W  = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
  localparam int RS_W   = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
  localparam int HOLD_W = $clog2(RESYNC_CYCLES + 1);

  localparam logic [CNT_W-1:0]     LAST_SMP = CNT_W'(FFT_SIZE - 1);
  localparam logic [FFT_IDX_W-1:0] LAST_IDX = FFT_IDX_W'(FFT_SIZE - 1);
  localparam logic [RS_W-1:0]      RS_LAST  = RS_W'(RESYNC_CYCLES - 1);
  localparam logic [HOLD_W-1:0]    HOLD_RST = HOLD_W'(RESYNC_CYCLES);

  fft_ctrl_state_e state, state_next;

  logic [CNT_W-1:0]      smp_cnt;
  logic [SKIP_WIDTH-1:0] skip_lat;
  logic [SKIP_WIDTH-1:0] skip_cnt;
  logic [RS_W-1:0]       rs_cnt;
  logic [HOLD_W-1:0]     hold_cnt;

  logic accept;
  logic last_smp;
  logic in_wait;
  logic wd_expired;
  logic frame_end;
  logic timeout_evt;
  logic forward;

  assign s_ready   = (state == ST_FILL) || (state == ST_SKIP);
  assign accept    = s_valid && s_ready;
  assign last_smp  = (smp_cnt == LAST_SMP);
  assign in_wait   = (state == ST_WAIT_OUT) || (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // A sample accepted in the same cycle as abort is dropped, so nothing is
  // presented to the FFT while it is being held in reset.
  assign forward = accept && (state == ST_FILL) && !abort;

  fft_ctrl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (wd_expired)
  );

  // Priority in every busy state: abort, then watchdog, then normal progress.
  always_comb begin
    state_next  = state;
    frame_end   = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_FILL;
      end
      ST_FILL: begin
        if (abort)                     state_next = ST_RESYNC;
        else if (accept && last_smp)   state_next = ST_WAIT_OUT;
      end
      ST_WAIT_OUT: begin
        if (abort) begin
          state_next = ST_RESYNC;
        end else if (wd_expired) begin
          timeout_evt = 1'b1;
          state_next  = ST_RESYNC;
        end else if (fft_valid) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_next = ST_RESYNC;
        end else if (wd_expired) begin
          timeout_evt = 1'b1;
          state_next  = ST_RESYNC;
        end else if (fft_valid && (fft_index == LAST_IDX)) begin
          frame_end = 1'b1;
          if (!enable)             state_next = ST_IDLE;
          else if (skip_lat != '0) state_next = ST_SKIP;
          else                     state_next = ST_FILL;
        end
      end
      ST_SKIP: begin
        if (abort) begin
          state_next = ST_RESYNC;
        end else if (accept && last_smp && (skip_cnt == skip_lat - 1'b1)) begin
          state_next = ST_FILL;
        end
      end
      ST_RESYNC: begin
        if (rs_cnt == RS_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      smp_cnt        <= '0;
      skip_lat       <= '0;
      skip_cnt       <= '0;
      rs_cnt         <= '0;
      hold_cnt       <= HOLD_RST;
      fft_rst_n      <= 1'b0;
      fft_data_valid <= 1'b0;
      fft_real_in    <= '0;
      fft_imag_in    <= '0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
      err_timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= frame_end;

      if (frame_end) frame_count <= frame_count + 1'b1;

      if (timeout_evt)                      err_timeout <= 1'b1;
      else if ((state == ST_IDLE) && enable) err_timeout <= 1'b0;

      if ((state == ST_IDLE) && enable) skip_lat <= skip_frames;

      // Sample/frame counters restart on every state change; within SKIP the
      // sample counter wraps naturally because FFT_SIZE is a power of two.
      if (state_next != state) begin
        smp_cnt  <= '0;
        skip_cnt <= '0;
      end else if (accept) begin
        smp_cnt <= smp_cnt + 1'b1;
        if ((state == ST_SKIP) && last_smp) skip_cnt <= skip_cnt + 1'b1;
      end

      if (state == ST_RESYNC) rs_cnt <= rs_cnt + 1'b1;
      else                    rs_cnt <= '0;

      // hold_cnt stretches fft_rst_n low for RESYNC_CYCLES after rst_n release;
      // afterwards fft_rst_n is low exactly while the FSM sits in RESYNC.
      if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      fft_rst_n <= (hold_cnt == '0) && (state_next != ST_RESYNC);

      fft_data_valid <= forward;
      if (forward) begin
        fft_real_in <= s_real;
        fft_imag_in <= s_imag;
      end
    end
  end

endmodule
